cordic_post_proc: RTL and testbench

Parametrised, pipelined output stage for the CORDIC rotator. It takes raw X/Y results, applies a full 4-quadrant correction and optional CORDIC gain compensation, then rounds and saturates. It sits between the CORDIC iteration core and downstream sine/cosine consumers. It carries a sideband tag through a valid/ready pipeline with back-pressure.

---
 rtl/cordic_pkg.sv | 23 ++
 rtl/cordic_round_sat.sv | 38 +++
 rtl/cordic_post_proc.sv | 184 ++++++++++++++++++
 tb/tb_cordic_post_proc.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and helpers for the CORDIC output stage.
package cordic_pkg;

  // Quadrant correction codes
  localparam logic [1:0] QUAD_0   = 2'b00;
  localparam logic [1:0] QUAD_90  = 2'b01;
  localparam logic [1:0] QUAD_180 = 2'b10;
  localparam logic [1:0] QUAD_270 = 2'b11;

  // 1/K ~= 0.60725 in Q0.16
  localparam int unsigned CORDIC_INV_K_Q16 = 39797;

  // Largest value representable in a w-bit two's complement word
  function automatic longint sat_max(input int unsigned w);
    return (longint'(1) << (w - 1)) - longint'(1);
  endfunction

  // Smallest value representable in a w-bit two's complement word
  function automatic longint sat_min(input int unsigned w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/cordic_round_sat.sv
// Round-half-up, arithmetic shift right and clamp of one signed channel.
module cordic_round_sat
  import cordic_pkg::*;
#(
  parameter int unsigned IN_W  = 34,
  parameter int unsigned SHIFT = 16,
  parameter int unsigned OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);

  // One guard bit so adding the rounding constant can never wrap
  localparam int unsigned RW = IN_W + 1;
  localparam logic signed [RW-1:0] RND   = RW'(1) << (SHIFT - 1);
  localparam logic signed [RW-1:0] MAX_V = RW'(sat_max(OUT_W));
  localparam logic signed [RW-1:0] MIN_V = RW'(sat_min(OUT_W));

  logic signed [RW-1:0] sum;
  logic signed [RW-1:0] shr;

  // Round, shift down and clamp to the output range
  always_comb begin
    sum  = {din[IN_W-1], din} + RND;
    shr  = sum >>> SHIFT;
    sat  = 1'b0;
    dout = shr[OUT_W-1:0];
    if (shr > MAX_V) begin
      sat  = 1'b1;
      dout = MAX_V[OUT_W-1:0];
    end else if (shr < MIN_V) begin
      sat  = 1'b1;
      dout = MIN_V[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/cordic_post_proc.sv
// CORDIC output stage: quadrant correction, gain compensation,
// round/saturate, as a 3-stage valid/ready pipeline with tag sideband.
module cordic_post_proc
  import cordic_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned GAIN_W    = 16,
  parameter int unsigned GAIN      = CORDIC_INV_K_Q16,
  parameter bit          GAIN_COMP = 1'b1,
  parameter int unsigned TAG_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] y_in,
  input  logic [1:0]        quad_in,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] cos_out,
  output logic [DATA_W-1:0] sin_out,
  output logic [TAG_W-1:0]  tag_out,
  output logic              sat_out,
  output logic              sat_sticky,
  input  logic              sat_clr
);

  localparam int unsigned CW = DATA_W + 1;
  localparam int unsigned PW = DATA_W + GAIN_W + 2;

  logic en1, en2, en3;

  logic                     v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic signed [CW-1:0]     c1_q, c1_d, s1_q, s1_d;
  logic [TAG_W-1:0]         t1_q, t1_d, t2_q, t2_d, tag_q, tag_d;
  logic signed [PW-1:0]     c2_q, c2_d, s2_q, s2_d;
  logic signed [DATA_W-1:0] cos_q, cos_d, sin_q, sin_d;
  logic                     sat_q, sat_d, sticky_q, sticky_d;

  logic signed [CW-1:0]     x_w, y_w, c_corr, s_corr;
  logic signed [PW-1:0]     c_ext, s_ext, g_ext, c_scaled, s_scaled;
  logic signed [DATA_W-1:0] c_rs, s_rs;
  logic                     c_sat, s_sat;

  // Stage enables: a stage may load when it is empty or its successor moves
  always_comb begin
    en3      = out_ready | ~v3_q;
    en2      = en3 | ~v2_q;
    en1      = en2 | ~v1_q;
    in_ready = en1;
  end

  // S1 datapath: widen by one bit so negating the most negative input is exact
  always_comb begin
    x_w    = {x_in[DATA_W-1], x_in};
    y_w    = {y_in[DATA_W-1], y_in};
    c_corr = x_w;
    s_corr = y_w;
    case (quad_in)
      QUAD_0:   begin c_corr = x_w;  s_corr = y_w;  end
      QUAD_90:  begin c_corr = -y_w; s_corr = x_w;  end
      QUAD_180: begin c_corr = -x_w; s_corr = -y_w; end
      QUAD_270: begin c_corr = y_w;  s_corr = -x_w; end
      default:  begin c_corr = x_w;  s_corr = y_w;  end
    endcase
  end

  // S2 datapath: bypass pre-shifts so S3 rounding is identical in both modes
  always_comb begin
    c_ext = {{(PW-CW){c1_q[CW-1]}}, c1_q};
    s_ext = {{(PW-CW){s1_q[CW-1]}}, s1_q};
    g_ext = {{(PW-GAIN_W){1'b0}}, GAIN[GAIN_W-1:0]};
    if (GAIN_COMP) begin
      c_scaled = c_ext * g_ext;
      s_scaled = s_ext * g_ext;
    end else begin
      c_scaled = c_ext <<< GAIN_W;
      s_scaled = s_ext <<< GAIN_W;
    end
  end

  cordic_round_sat #(
    .IN_W  (PW),
    .SHIFT (GAIN_W),
    .OUT_W (DATA_W)
  ) u_rs_cos (
    .din  (c2_q),
    .dout (c_rs),
    .sat  (c_sat)
  );

  cordic_round_sat #(
    .IN_W  (PW),
    .SHIFT (GAIN_W),
    .OUT_W (DATA_W)
  ) u_rs_sin (
    .din  (s2_q),
    .dout (s_rs),
    .sat  (s_sat)
  );

  // Next-state for all stages; data only loads alongside a valid sample
  always_comb begin
    v1_d     = en1 ? in_valid : v1_q;
    c1_d     = c1_q;
    s1_d     = s1_q;
    t1_d     = t1_q;
    if (en1 && in_valid) begin
      c1_d = c_corr;
      s1_d = s_corr;
      t1_d = tag_in;
    end

    v2_d     = en2 ? v1_q : v2_q;
    c2_d     = c2_q;
    s2_d     = s2_q;
    t2_d     = t2_q;
    if (en2 && v1_q) begin
      c2_d = c_scaled;
      s2_d = s_scaled;
      t2_d = t1_q;
    end

    v3_d     = en3 ? v2_q : v3_q;
    cos_d    = cos_q;
    sin_d    = sin_q;
    tag_d    = tag_q;
    sat_d    = sat_q;
    if (en3 && v2_q) begin
      cos_d = c_rs;
      sin_d = s_rs;
      tag_d = t2_q;
      sat_d = c_sat | s_sat;
    end

    // set dominates a same-cycle clear
    sticky_d = (sticky_q & ~sat_clr) | (v3_q & out_ready & sat_q);
  end

  // Pipeline and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      c1_q     <= '0;
      s1_q     <= '0;
      t1_q     <= '0;
      c2_q     <= '0;
      s2_q     <= '0;
      t2_q     <= '0;
      cos_q    <= '0;
      sin_q    <= '0;
      tag_q    <= '0;
      sat_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      c1_q     <= c1_d;
      s1_q     <= s1_d;
      t1_q     <= t1_d;
      c2_q     <= c2_d;
      s2_q     <= s2_d;
      t2_q     <= t2_d;
      cos_q    <= cos_d;
      sin_q    <= sin_d;
      tag_q    <= tag_d;
      sat_q    <= sat_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_valid  = v3_q;
  assign cos_out    = cos_q;
  assign sin_out    = sin_q;
  assign tag_out    = tag_q;
  assign sat_out    = sat_q;
  assign sat_sticky = sticky_q;

endmodule

// File: tb/tb_cordic_post_proc.sv
// Bench for cordic_post_proc: one bypass and one gain-compensated instance
// share stimulus; a queue scoreboard with an arithmetic model checks both.
module tb_cordic_post_proc;

  localparam int DW = 16;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          sat_clr = 1'b0;
  logic [DW-1:0] x_in = '0;
  logic [DW-1:0] y_in = '0;
  logic [1:0]    quad_in = '0;
  logic [TW-1:0] tag_in = '0;

  // index 0: GAIN_COMP=0, index 1: GAIN_COMP=1
  logic [1:0]          in_ready, out_valid, sat_out, sat_sticky;
  logic [1:0][DW-1:0]  cos_out, sin_out;
  logic [1:0][TW-1:0]  tag_out;

  always #5 clk = ~clk;

  cordic_post_proc #(.DATA_W(DW), .GAIN_W(16), .GAIN(39797), .GAIN_COMP(1'b0), .TAG_W(TW)) u_dut_bypass (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .x_in(x_in), .y_in(y_in), .quad_in(quad_in), .tag_in(tag_in),
    .out_valid(out_valid[0]), .out_ready(out_ready), .cos_out(cos_out[0]), .sin_out(sin_out[0]),
    .tag_out(tag_out[0]), .sat_out(sat_out[0]), .sat_sticky(sat_sticky[0]), .sat_clr(sat_clr));

  cordic_post_proc #(.DATA_W(DW), .GAIN_W(16), .GAIN(39797), .GAIN_COMP(1'b1), .TAG_W(TW)) u_dut_comp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .x_in(x_in), .y_in(y_in), .quad_in(quad_in), .tag_in(tag_in),
    .out_valid(out_valid[1]), .out_ready(out_ready), .cos_out(cos_out[1]), .sin_out(sin_out[1]),
    .tag_out(tag_out[1]), .sat_out(sat_out[1]), .sat_sticky(sat_sticky[1]), .sat_clr(sat_clr));

  typedef struct {
    longint        c;
    longint        s;
    bit            sat;
    logic [TW-1:0] tag;
    int            t;
  } exp_t;

  exp_t sb [2][$];
  exp_t last [2];
  bit   sticky_m [2];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_out0 = 0;

  task automatic check_val(input string tag, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Scale one corrected value, round half up, clamp to 16 bits
  function automatic void scale(input longint v, input bit comp, output longint o, output bit sat);
    longint p;
    p   = comp ? v * 39797 : v * 65536;
    o   = (p + 32768) >>> 16;
    sat = 1'b0;
    if (o > 32767)  begin o = 32767;  sat = 1'b1; end
    if (o < -32768) begin o = -32768; sat = 1'b1; end
  endfunction

  function automatic exp_t model(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                 input logic [1:0] q, input logic [TW-1:0] tg, input bit comp);
    exp_t   r;
    longint xv, yv, c, s;
    bit     sc, ss;
    xv = longint'($signed(x));
    yv = longint'($signed(y));
    case (q)
      2'd0:    begin c = xv;  s = yv;  end
      2'd1:    begin c = -yv; s = xv;  end
      2'd2:    begin c = -xv; s = -yv; end
      default: begin c = yv;  s = -xv; end
    endcase
    scale(c, comp, r.c, sc);
    scale(s, comp, r.s, ss);
    r.sat = sc | ss;
    r.tag = tg;
    r.t   = 0;
    return r;
  endfunction

  // Drive one cycle of inputs at the falling edge and check both instances
  task automatic cycle(input bit v, input logic [DW-1:0] x, input logic [DW-1:0] y,
                       input logic [1:0] qd, input logic [TW-1:0] tg,
                       input bit ordy, input bit clr, output bit acc);
    bit   exp_ir, exp_ov;
    exp_t e;
    @(negedge clk);
    in_valid = v; x_in = x; y_in = y; quad_in = qd; tag_in = tg;
    out_ready = ordy; sat_clr = clr;
    #1;
    acc = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_ir = ordy || (sb[i].size() < 3);
      check_val($sformatf("in_ready[%0d]", i), longint'(in_ready[i]), longint'(exp_ir));
      // the oldest sample never waits on anything ahead, so it reaches S3 in 3 cycles
      exp_ov = (sb[i].size() > 0) && (cyc - sb[i][0].t >= 3);
      check_val($sformatf("out_valid[%0d]", i), longint'(out_valid[i]), longint'(exp_ov));
      check_val($sformatf("sat_sticky[%0d]", i), longint'(sat_sticky[i]), longint'(sticky_m[i]));
      if (exp_ov) begin
        e = sb[i][0];
        check_val($sformatf("cos[%0d]", i), longint'($signed(cos_out[i])), e.c);
        check_val($sformatf("sin[%0d]", i), longint'($signed(sin_out[i])), e.s);
        check_val($sformatf("tag[%0d]", i), longint'(tag_out[i]), longint'(e.tag));
        check_val($sformatf("sat_out[%0d]", i), longint'(sat_out[i]), longint'(e.sat));
      end
      if (clr) sticky_m[i] = 1'b0;
      if (exp_ov && ordy) begin
        e = sb[i].pop_front();
        last[i] = e;
        if (e.sat) sticky_m[i] = 1'b1;
        if (i == 0) n_out0++;
      end
      if (v && exp_ir) begin
        e   = model(x, y, qd, tg, (i == 1));
        e.t = cyc;
        sb[i].push_back(e);
        if (i == 0) acc = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] y,
                      input logic [1:0] q, input logic [TW-1:0] tg);
    bit a;
    cycle(1'b1, x, y, q, tg, 1'b1, 1'b0, a);
  endtask

  task automatic idle(input int n, input bit clr);
    bit a;
    for (int k = 0; k < n; k++) cycle(1'b0, '0, '0, 2'd0, '0, 1'b1, clr, a);
  endtask

  task automatic check_reset_state(input string nm);
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("%s_out_valid[%0d]", nm, i), longint'(out_valid[i]), 0);
      check_val($sformatf("%s_in_ready[%0d]", nm, i), longint'(in_ready[i]), 1);
      check_val($sformatf("%s_cos[%0d]", nm, i), longint'(cos_out[i]), 0);
      check_val($sformatf("%s_sin[%0d]", nm, i), longint'(sin_out[i]), 0);
      check_val($sformatf("%s_tag[%0d]", nm, i), longint'(tag_out[i]), 0);
      check_val($sformatf("%s_sat[%0d]", nm, i), longint'(sat_out[i]), 0);
      check_val($sformatf("%s_sticky[%0d]", nm, i), longint'(sat_sticky[i]), 0);
      sb[i].delete();
      sticky_m[i] = 1'b0;
    end
  endtask

  initial begin
    bit            a;
    int            idx;
    bit [7:0]      seen;
    logic [DW-1:0] rx, ry;
    int            pick;

    sticky_m[0] = 1'b0;
    sticky_m[1] = 1'b0;

    // Reset state
    #2;
    check_reset_state("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Bypass, 90 degrees
    send(16'd1000, 16'(-2000), 2'd1, 4'd1);
    idle(4, 1'b0);
    check_val("t1_cos", last[0].c, 2000);
    check_val("t1_sin", last[0].s, 1000);
    check_val("t1_sat", longint'(last[0].sat), 0);

    // Gain compensated, 0 degrees
    send(16'd16384, 16'd0, 2'd0, 4'd2);
    idle(4, 1'b0);
    check_val("t2_cos", last[1].c, 9949);
    check_val("t2_sin", last[1].s, 0);

    // Negating the most negative value saturates in bypass mode
    send(16'h8000, 16'd5, 2'd2, 4'd3);
    idle(4, 1'b0);
    check_val("t3_cos", last[0].c, 32767);
    check_val("t3_sin", last[0].s, -5);
    check_val("t3_sat", longint'(last[0].sat), 1);
    check_val("t3_sticky_set", longint'(sat_sticky[0]), 1);
    idle(1, 1'b1);
    idle(1, 1'b0);
    check_val("t3_sticky_clr", longint'(sat_sticky[0]), 0);

    // Clear and a saturating transfer in the same cycle
    send(16'h8000, 16'd5, 2'd2, 4'd4);
    idle(2, 1'b0);
    cycle(1'b0, '0, '0, 2'd0, '0, 1'b1, 1'b1, a);
    idle(1, 1'b0);
    check_val("t4_sticky_set_wins", longint'(sat_sticky[0]), 1);
    idle(1, 1'b1);

    // Tagged stream with out_ready pattern 1,0,0 repeating
    idx = 0;
    seen = '0;
    n_out0 = 0;
    for (int k = 0; k < 40; k++) begin
      cycle(idx < 8, 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)), 4'(idx),
            (k % 3) == 0, 1'b0, a);
      if (n_out0 > 0) seen[last[0].tag[2:0]] = 1'b1;
      if (a) idx++;
    end
    check_val("t5_emitted", longint'(n_out0), 8);
    check_val("t5_last_tag", longint'(last[0].tag), 7);
    check_val("t5_tags_seen", longint'(seen), 255);

    // Reset with two samples in flight
    send(16'd300, 16'd400, 2'd3, 4'd5);
    send(16'd500, 16'd600, 2'd1, 4'd6);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    send(16'd1000, 16'(-2000), 2'd1, 4'd9);
    idle(4, 1'b0);
    check_val("t6_cos", last[0].c, 2000);
    check_val("t6_tag", longint'(last[0].tag), 9);

    // Random traffic with back-pressure
    for (int k = 0; k < 600; k++) begin
      pick = $urandom_range(0, 7);
      rx = (pick == 0) ? 16'h8000 : (pick == 1) ? 16'h7fff : 16'($urandom);
      pick = $urandom_range(0, 7);
      ry = (pick == 0) ? 16'h8000 : (pick == 1) ? 16'h7fff : 16'($urandom);
      cycle($urandom_range(0, 3) != 0, rx, ry, 2'($urandom_range(0, 3)), 4'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, a);
    end
    idle(6, 1'b0);
    check_val("drain0", longint'(sb[0].size()), 0);
    check_val("drain1", longint'(sb[1].size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
